// File: rtl/tx_shift_pkg.sv
// Shared comm definitions for the TX/RX block shifters: byte width,
// default block size and the serializer state encoding.
package tx_shift_pkg;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } shift_state_t;

  function automatic logic [BYTE_W-1:0] top_byte(input logic [8*NBYTES_DEF-1:0] blk);
    return blk[8*NBYTES_DEF-1 -: BYTE_W];
  endfunction

endpackage

// File: rtl/tx_shift.sv
// TX block serializer: loads one block and hands it to the UART transmitter
// one byte at a time, most-significant byte first.
//
// state | meaning
// IDLE  | ready for a block; load accepted here only
// SEND  | one cycle, tx_start high, d_out shows the current byte
// WAIT  | d_out held, waiting for the UART's tx_done
// DONE  | one cycle, shift_done high, then back to IDLE
module tx_shift
  import tx_shift_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BYTE_W*NBYTES-1:0] d_in,
  input  logic                     load,
  output logic                     ready,
  output logic [BYTE_W-1:0]        d_out,
  output logic                     tx_start,
  input  logic                     tx_done,
  output logic                     busy,
  output logic                     shift_done
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  shift_state_t      r_state;
  shift_state_t      w_next;
  logic [W-1:0]      r_shift;
  logic [CW-1:0]     r_ctr;
  logic [BYTE_W-1:0] r_dout;
  logic              r_tx_start;
  logic              r_shift_done;
  logic              w_accept;
  logic              w_advance;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_accept = 1'b1;
          w_next   = ST_SEND;
        end
      end
      ST_SEND: w_next = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          if (r_ctr == LAST) begin
            w_next = ST_DONE;
          end else begin
            w_advance = 1'b1;
            w_next    = ST_SEND;
          end
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_ctr        <= '0;
      r_dout       <= '0;
      r_tx_start   <= 1'b0;
      r_shift_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_tx_start   <= (w_next == ST_SEND);
      r_shift_done <= (w_next == ST_DONE);
      if (w_accept) begin
        r_shift <= d_in;
        r_ctr   <= '0;
        r_dout  <= d_in[W-1 -: BYTE_W];
      end else if (w_advance) begin
        r_shift <= r_shift << BYTE_W;
        r_ctr   <= r_ctr + 1'b1;
        r_dout  <= r_shift[W-BYTE_W-1 -: BYTE_W];
      end
    end
  end

  assign ready      = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign d_out      = r_dout;
  assign tx_start   = r_tx_start;
  assign shift_done = r_shift_done;

endmodule

// File: tb/tb_tx_shift.sv
// Directed bench for tx_shift: a simple UART responder, a pulse monitor,
// and immediate-assertion checks against hand-computed byte sequences.
module tb_tx_shift;
  import tx_shift_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] d_in = '0;
  logic         load = 1'b0;
  logic         tx_done = 1'b0;
  logic         ready, tx_start, busy, shift_done;
  logic [7:0]   d_out;

  int checks = 0;
  int errors = 0;

  tx_shift #(.NBYTES(16)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .load(load), .ready(ready),
    .d_out(d_out), .tx_start(tx_start), .tx_done(tx_done), .busy(busy),
    .shift_done(shift_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic [7:0]  cap[$];
  int unsigned cap_cyc[$];
  int unsigned sd_cyc = 0;
  int          n_sd = 0, n_both = 0, n_wide = 0;
  logic        prev_start = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start) begin
      cap.push_back(d_out);
      cap_cyc.push_back(cyc);
    end
    if (shift_done) begin
      n_sd++;
      sd_cyc = cyc;
    end
    if (tx_start && shift_done) n_both++;
    if (tx_start && prev_start) n_wide++;
    prev_start = tx_start;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Serve one byte; hold = tx_done width, early = extra tx_done pulse during SEND.
  task automatic serve_byte(input int hold, input bit early);
    bit ok;
    int n0;
    wait_start(ok);
    check("tx_start_timeout", 128'(ok), 128'd1);
    if (early) begin
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n0 = cap.size();
      repeat (5) tick();
      check("send_ignores_done", 128'(cap.size()), 128'(n0));
    end else begin
      repeat (3) tick();
    end
    repeat (6) tick();
    check("d_out_stable", 128'(d_out), 128'(cap[$]));
    check("busy_ready_wait", {126'd0, busy, ready}, 128'b10);
    tx_done = 1'b1;
    repeat (hold) tick();
    tx_done = 1'b0;
  endtask

  task automatic check_block(input int base, input logic [127:0] blk);
    logic [7:0] obs;
    for (int i = 0; i < 16; i++) begin
      obs = (base + i < cap.size()) ? cap[base + i] : 8'hxx;
      check($sformatf("byte%0d", i), 128'(obs), 128'(blk[127 - 8*i -: 8]));
    end
  endtask

  task automatic load_block(input logic [127:0] blk);
    d_in = blk;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic finish_block();
    check("shift_done_pulse", 128'(shift_done), 128'd1);
    tick();
    check("ready_after_block", {126'd0, busy, ready}, 128'b01);
  endtask

  localparam logic [127:0] BLK_A  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BLK_LB = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam logic [127:0] BLK_F  = {16{8'hFF}};
  localparam logic [127:0] BLK_5  = {16{8'hA5}};

  initial begin
    int base, base2, n0, sd0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("reset_state", {119'd0, ready, busy, tx_start, shift_done, d_out},
          {119'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

    // plain block, MSB first
    base = cap.size();
    load_block(BLK_A);
    for (int i = 0; i < 16; i++) serve_byte(1, 1'b0);
    finish_block();
    check("plain_starts", 128'(cap.size() - base), 128'd16);
    check_block(base, BLK_A);

    // loopback order: first received byte sits in the top byte
    base = cap.size();
    load_block(BLK_LB);
    for (int i = 0; i < 16; i++) serve_byte(1, 1'b0);
    finish_block();
    check_block(base, BLK_LB);

    // tx_done held 5 cycles on byte 1 sends bytes 2,3,4 back-to-back; early pulse on byte 6 ignored
    base = cap.size();
    load_block(BLK_A);
    serve_byte(1, 1'b0);
    serve_byte(5, 1'b0);
    check("hold5_starts", 128'(cap.size() - base), 128'd5);
    for (int i = 2; i < 14; i++) serve_byte(1, i == 4);
    finish_block();
    check("hold_total_starts", 128'(cap.size() - base), 128'd16);
    check_block(base, BLK_A);

    // load held high with new data: ignored until ready, then accepted back-to-back
    base = cap.size();
    d_in = BLK_A;
    load = 1'b1;
    tick();
    d_in = BLK_F;
    for (int i = 0; i < 16; i++) serve_byte(1, 1'b0);
    check("shift_done_b2b", 128'(shift_done), 128'd1);
    check("ready_low_in_done", 128'(ready), 128'd0);
    tick();
    check("ready_idle_b2b", 128'(ready), 128'd1);
    tick();
    load = 1'b0;
    check("second_accepted", 128'(tx_start), 128'd1);
    check("b2b_gap", 128'(cap_cyc[$] - sd_cyc), 128'd2);
    base2 = cap.size() - 1;
    for (int i = 0; i < 16; i++) serve_byte(1, 1'b0);
    finish_block();
    check_block(base, BLK_A);
    check_block(base2, BLK_F);

    // reset after the 7th tx_done discards the block
    load_block(BLK_A);
    for (int i = 0; i < 7; i++) serve_byte(1, 1'b0);
    check("pre_reset_start", 128'(tx_start), 128'd1);
    sd0 = n_sd;
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", {119'd0, ready, busy, tx_start, shift_done, d_out},
          {119'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("post_reset_ready", {126'd0, busy, ready}, 128'b01);
    n0 = cap.size();
    repeat (20) tick();
    check("no_shift_done_after_reset", 128'(n_sd), 128'(sd0));
    check("no_start_after_reset", 128'(cap.size()), 128'(n0));
    base = cap.size();
    load_block(BLK_5);
    for (int i = 0; i < 16; i++) serve_byte(1, 1'b0);
    finish_block();
    check_block(base, BLK_5);

    check("shift_done_count", 128'(n_sd), 128'd6);
    check("start_and_done_together", 128'(n_both), 128'd0);
    check("start_wider_than_one", 128'(n_wide), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
